// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
// Holds the FSM state enum, word size and default parameters.
package dmem_pkg;

  localparam int WORD_BYTES    = 8;
  localparam int DEF_LATENCY   = 3;
  localparam int DEF_ADDR_BITS = 10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between a requester and the data memory.
// master drives req_*; slave drives stall and resp_*.
interface dmem_if;

  logic        req_valid;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic [63:0] resp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  stall, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output stall, resp_valid, resp_data
  );

endinterface

// File: rtl/dmem_bytearray.sv
// Byte storage with one 8-byte big-endian port; offsets wrap.
// Ports: clk, we, addr (byte index), wdata, rdata (combinational).
module dmem_bytearray
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [63:0]          wdata,
  output logic [63:0]          rdata
);

  logic [7:0] mem [2**ADDR_BITS];

  // Lowest address holds the most significant byte.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < WORD_BYTES; i++)
      rdata[63-8*i -: 8] = mem[addr + ADDR_BITS'(i)];
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++)
        mem[addr + ADDR_BITS'(i)] <= wdata[63-8*i -: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data memory: accepts one request, waits, responds.
// Ports: clk, reset_n (async, active-low), bus (dmem_if.slave).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY   = DEF_LATENCY,
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic  clk,
  input  logic  reset_n,
  dmem_if.slave bus
);

  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  state_e               state;
  logic [CW-1:0]        cnt;
  logic                 cap_we;
  logic [ADDR_BITS-1:0] cap_addr;
  logic [63:0]          cap_wdata;
  logic                 resp_valid_q;
  logic [63:0]          resp_data_q;

  logic                 go;
  logic                 eff_we;
  logic [ADDR_BITS-1:0] eff_addr;
  logic [63:0]          eff_wdata;
  logic [63:0]          rdata;
  logic                 mem_we;
  logic                 unused_addr;

  assign unused_addr = ^bus.req_addr[63:ADDR_BITS];

  // With zero latency the access happens on the accept edge,
  // so the live request feeds the array instead of the captures.
  always_comb begin
    if (LATENCY == 0) begin
      go        = (state == IDLE) && bus.req_valid;
      eff_we    = bus.req_we;
      eff_addr  = bus.req_addr[ADDR_BITS-1:0];
      eff_wdata = bus.req_wdata;
    end else begin
      go        = (state == WAIT) && (cnt == '0);
      eff_we    = cap_we;
      eff_addr  = cap_addr;
      eff_wdata = cap_wdata;
    end
  end

  // Gating with reset_n drops a store caught by reset.
  assign mem_we = go && eff_we && reset_n;

  dmem_bytearray #(
    .ADDR_BITS(ADDR_BITS)
  ) u_arr (
    .clk  (clk),
    .we   (mem_we),
    .addr (eff_addr),
    .wdata(eff_wdata),
    .rdata(rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      cap_we       <= 1'b0;
      cap_addr     <= '0;
      cap_wdata    <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= go;
      if (go)
        resp_data_q <= eff_we ? eff_wdata : rdata;
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            cap_we    <= bus.req_we;
            cap_addr  <= bus.req_addr[ADDR_BITS-1:0];
            cap_wdata <= bus.req_wdata;
            if (LATENCY == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CW'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == '0)
            state <= RESP;
          else
            cnt <= cnt - 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall      = bus.req_valid && (state != RESP);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-array model.
// Covers LATENCY=3 (main) and LATENCY=0 instances.
module tb_dmem_responder;

  localparam int L   = 3;
  localparam int MSZ = 1024;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  dmem_if bus3();
  dmem_if bus0();

  dmem_responder #(.LATENCY(L), .ADDR_BITS(10)) dut3 (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus3)
  );

  dmem_responder #(.LATENCY(0), .ADDR_BITS(10)) dut0 (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus0)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mdl [MSZ];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int idx(input logic [63:0] a, input int i);
    return (int'(a[9:0]) + i) % MSZ;
  endfunction

  function automatic logic [63:0] mrd(input logic [63:0] a);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 8; i++)
      w = {w[55:0], mdl[idx(a, i)]};
    return w;
  endfunction

  task automatic mwr(input logic [63:0] a, input logic [63:0] d);
    for (int i = 0; i < 8; i++)
      mdl[idx(a, i)] = d[63-8*i -: 8];
  endtask

  // Starts just after a rising edge. mode: 0 plain, 1 change req
  // in cycle 2, 2 drop req_valid in cycle 2, 3 reset in cycle 2.
  task automatic xact(input logic we, input logic [63:0] a,
                      input logic [63:0] wd, input int mode,
                      input bit b2b, output logic [63:0] rd);
    logic [63:0] exp;
    int cyc, st;
    bit seen, bad;
    exp = we ? wd : mrd(a);
    bus3.req_valid = 1'b1;
    bus3.req_we    = we;
    bus3.req_addr  = a;
    bus3.req_wdata = wd;
    cyc  = 0;
    st   = 0;
    seen = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      if (bus3.stall) st++;
      if (bus3.resp_valid) begin
        seen = 1;
      end else begin
        @(posedge clk);
        #1;
        cyc++;
        if (cyc == 2 && mode == 1) begin
          bus3.req_addr  = a + 64'd8;
          bus3.req_wdata = ~wd;
          bus3.req_we    = ~we;
        end
        if (cyc == 2 && mode == 2) bus3.req_valid = 1'b0;
        if (cyc == 2 && mode == 3) begin
          bus3.req_valid = 1'b0;
          reset_n = 1'b0;
          break;
        end
      end
    end
    if (mode == 3) begin
      bad = 0;
      repeat (3) begin
        @(negedge clk);
        if (bus3.resp_valid || bus3.stall) bad = 1;
      end
      chk("rst_abort", 64'(bad), 64'd0);
      chk("rst_data", bus3.resp_data, 64'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      rd = '0;
      return;
    end
    chk("latency", 64'(cyc), 64'(L + 1));
    chk("stall_cycles", 64'(st), 64'((mode == 2) ? 2 : L + 1));
    chk("resp_data", bus3.resp_data, exp);
    rd = bus3.resp_data;
    if (we) mwr(a, wd);
    @(posedge clk);
    #1;
    if (!b2b) begin
      bus3.req_valid = 1'b0;
      @(negedge clk);
      chk("idle_rv", 64'(bus3.resp_valid), 64'd0);
      chk("hold_data", bus3.resp_data, exp);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [63:0] rd, wd, a;
    reset_n = 1'b0;
    bus3.req_valid = 1'b0;
    bus3.req_we    = 1'b0;
    bus3.req_addr  = '0;
    bus3.req_wdata = '0;
    bus0.req_valid = 1'b0;
    bus0.req_we    = 1'b0;
    bus0.req_addr  = '0;
    bus0.req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_rv", 64'(bus3.resp_valid), 64'd0);
    chk("rst_stall", 64'(bus3.stall), 64'd0);
    chk("rst_data", bus3.resp_data, 64'd0);
    chk("rst_rv0", 64'(bus0.resp_valid), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < MSZ; i += 8)
      xact(1'b1, 64'(i), {$urandom, $urandom}, 0, i[3], rd);

    xact(1'b1, 64'h10, 64'h0011223344556677, 0, 1'b0, rd);
    xact(1'b1, 64'h18, 64'h8899AABBCCDDEEFF, 0, 1'b0, rd);
    xact(1'b0, 64'h12, 64'h0, 0, 1'b0, rd);
    chk("ld_0x12", rd, 64'h2233445566778899);

    xact(1'b1, 64'h3FD, 64'h0102030405060708, 0, 1'b0, rd);
    xact(1'b0, 64'h3FD, 64'h0, 0, 1'b0, rd);
    chk("ld_wrap", rd, 64'h0102030405060708);
    xact(1'b0, 64'h0, 64'h0, 0, 1'b0, rd);
    chk("byte0", 64'(rd[63:56]), 64'h04);

    wd = {$urandom, $urandom};
    xact(1'b1, 64'h20, wd, 1, 1'b0, rd);
    xact(1'b0, 64'h20, 64'h0, 0, 1'b0, rd);
    chk("ld_orig", rd, wd);
    xact(1'b0, 64'h28, 64'h0, 0, 1'b0, rd);

    xact(1'b1, 64'h40, 64'hAAAAAAAAAAAAAAAA, 0, 1'b0, rd);
    xact(1'b1, 64'h40, {$urandom, $urandom}, 3, 1'b0, rd);
    xact(1'b0, 64'h40, 64'h0, 0, 1'b0, rd);
    chk("ld_after_rst", rd, 64'hAAAAAAAAAAAAAAAA);

    wd = {$urandom, $urandom};
    xact(1'b1, 64'h77, wd, 2, 1'b0, rd);
    xact(1'b0, 64'h77, 64'h0, 0, 1'b0, rd);
    chk("ld_drop", rd, wd);

    for (int i = 0; i < 60; i++) begin
      a = {$urandom, $urandom};
      xact(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 0,
           1'($urandom_range(0, 1)), rd);
    end
    bus3.req_valid = 1'b0;

    wd = {$urandom, $urandom};
    bus0.req_valid = 1'b1;
    bus0.req_we    = 1'b1;
    bus0.req_addr  = 64'h100;
    bus0.req_wdata = wd;
    @(negedge clk);
    chk("l0_st_stall", 64'(bus0.stall), 64'd1);
    chk("l0_st_rv0", 64'(bus0.resp_valid), 64'd0);
    @(negedge clk);
    chk("l0_st_rv1", 64'(bus0.resp_valid), 64'd1);
    chk("l0_st_data", bus0.resp_data, wd);
    @(posedge clk);
    #1;
    bus0.req_we    = 1'b0;
    bus0.req_wdata = '0;
    @(negedge clk);
    chk("l0_ld_stall0", 64'(bus0.stall), 64'd1);
    chk("l0_ld_rv0", 64'(bus0.resp_valid), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("l0_ld_rv1", 64'(bus0.resp_valid), 64'd1);
    chk("l0_ld_stall1", 64'(bus0.stall), 64'd0);
    chk("l0_ld_data", bus0.resp_data, wd);
    @(posedge clk);
    #1;
    bus0.req_valid = 1'b0;
    @(negedge clk);
    chk("l0_idle_rv", 64'(bus0.resp_valid), 64'd0);
    chk("l0_hold", bus0.resp_data, wd);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The module SHALL have parameter LATENCY, default 3, meaning the number of wait cycles between request accept and response (0 allowed).
REQ-002 The module SHALL have parameter ADDR_BITS, default 10, meaning log2 of the backing store size in bytes.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port req_valid, input, 1 bit: a request is presented.
REQ-006 The module SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 The module SHALL have port req_addr, input, 64 bits: byte address.
REQ-008 The module SHALL have port req_wdata, input, 64 bits: store data.
REQ-009 The module SHALL have port stall, output, 1 bit: requester holds its pipeline and request.
REQ-010 The module SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 The module SHALL have port resp_data, output, 64 bits: load data, or echoed store data.

Function
REQ-012 The module SHALL hold 2^ADDR_BITS bytes; the word at index a is big-endian: byte a maps to bits [63:56] and byte a+7 to bits [7:0].
REQ-013 The index a SHALL be req_addr[ADDR_BITS-1:0]; byte offsets a+i SHALL wrap modulo 2^ADDR_BITS, with no alignment requirement.
REQ-014 The FSM states SHALL be IDLE, WAIT and RESP.
REQ-015 In IDLE, a rising edge with req_valid=1 SHALL capture addr, we and wdata, then go to WAIT with counter=LATENCY-1, or go directly to RESP if LATENCY=0.
REQ-016 WAIT SHALL decrement the counter each cycle; when the counter is 0 it SHALL go to RESP on the next edge.
REQ-017 RESP SHALL return to IDLE unconditionally after one cycle.
REQ-018 stall SHALL be combinational: stall = req_valid && (state != RESP).
REQ-019 A request asserted in cycle 0 SHALL produce resp_valid=1 in cycle LATENCY+1, with stall=1 in cycles 0..LATENCY.
REQ-020 The store commit and load read SHALL both occur on the edge entering RESP, using the captured values only.
REQ-021 Changes on req_* after accept SHALL be ignored.
REQ-022 resp_data SHALL be registered: captured wdata for stores and the read word for loads; it SHALL hold its value outside RESP.
REQ-023 resp_valid SHALL be 1 only in RESP.
REQ-024 If req_valid drops during WAIT, the transaction SHALL still complete and pulse resp_valid.
REQ-025 A new request in the cycle after RESP SHALL be accepted from IDLE; the minimum request spacing is LATENCY+2 cycles.

Reset
REQ-026 On reset_n=0 the module SHALL set state=IDLE, counter=0, resp_valid=0, resp_data=0; stall then follows REQ-018 (0 while req_valid=0).
REQ-027 Reset SHALL NOT clear the byte storage; an uncommitted store interrupted by reset SHALL be discarded.

Structure
REQ-028 Package dmem_pkg SHALL hold the state enum, WORD_BYTES=8, and default LATENCY/ADDR_BITS constants.
REQ-029 Sub-module dmem_bytearray SHALL implement the byte storage with one 8-byte, big-endian, wrapping read/write port.

Verification (LATENCY=3 unless stated)
REQ-030 Reset with req_valid=0 -> resp_valid=0, stall=0, resp_data=0.
REQ-031 Store 0x0011223344556677 @0x10, then store 0x8899AABBCCDDEEFF @0x18, then load @0x12 -> stall=1 for 4 cycles per request; the load's resp_valid fires at cycle 4 with resp_data=0x2233445566778899.
REQ-032 Store 0x0102030405060708 @0x3FD, then load @0x3FD -> resp_data=0x0102030405060708, and byte 0x000=0x04.
REQ-033 Change req_addr and req_wdata in cycle 2 of a store @0x20 -> only the original address and data are committed; the load @0x20 returns the original data.
REQ-034 Assert reset_n=0 during WAIT of a store @0x40 (prior content 0xAA..AA) -> no resp_valid; a subsequent load @0x40 returns 0xAAAAAAAAAAAAAAAA.
REQ-035 With LATENCY=0, a load asserted in cycle 0 -> resp_valid=1 in cycle 1, stall=1 in cycle 0 only.
